// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package ifetch_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] inst_t;
    typedef logic [14:0] waddr_t;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fetch_entry_t;

    typedef struct packed {
        logic  v;
        addr_t pc;
    } inflight_t;

    localparam int unsigned IFETCH_MEM_LAT   = 2;
    localparam int unsigned IFETCH_BUF_DEPTH = 4;

    // Instructions are halfword aligned; bit 0 of any byte PC is dropped.
    function automatic addr_t align_pc(addr_t pc);
        return {pc[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Instruction buffer: small synchronous FIFO of {pc, inst} entries with flush.
// Overflow/underflow protection is left to the caller's credit scheme.
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = IFETCH_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;

    function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Entry storage; a flush only resets the pointers, stale data is unreachable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC generation, fixed-latency memory tracking,
// instruction buffer and valid/ready delivery to decode.
// Optional performance counters are enabled with the IFETCH_PERF_EN macro.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned MEM_LAT   = IFETCH_MEM_LAT,
    parameter int unsigned BUF_DEPTH = IFETCH_BUF_DEPTH,
    parameter addr_t       RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [14:0] imem_raddr,
    input  logic [15:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [15:0] perf_squashed
`endif
);

    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

    addr_t           fetch_pc_q;
    inflight_t       stage_q [MEM_LAT];
    logic [CntW-1:0] buf_count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    int unsigned     occupancy;
    logic            issue, push, pop;

    // Credit check counts buffered plus in-flight words; a same-cycle pop is not credited.
    always_comb begin
        occupancy = 32'(buf_count);
        for (int i = 0; i < MEM_LAT; i++) occupancy += 32'(stage_q[i].v);
        issue      = !redirect_valid && (occupancy < BUF_DEPTH);
        inst_valid = (buf_count != '0) && !redirect_valid;
        pop        = inst_valid && inst_ready;
        push       = stage_q[MEM_LAT-1].v && !redirect_valid;
        push_entry = '{pc: stage_q[MEM_LAT-1].pc, inst: imem_rdata};
    end

    assign imem_raddr = fetch_pc_q[15:1];
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

    // Fetch PC: redirect target, else advance one halfword per issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= align_pc(RESET_PC);
        end else if (redirect_valid) begin
            fetch_pc_q <= align_pc(redirect_pc);
        end else if (issue) begin
            fetch_pc_q <= fetch_pc_q + 16'd2;
        end
    end

    // In-flight tracker mirroring the memory pipeline; the last stage lines up with imem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) stage_q[i] <= '0;
        end else if (redirect_valid) begin
            for (int i = 0; i < MEM_LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= '{v: issue, pc: fetch_pc_q};
            for (int i = 1; i < MEM_LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    ifetch_buf #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .flush    (redirect_valid),
        .head     (head),
        .count    (buf_count)
    );

    credit_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
        occupancy <= BUF_DEPTH);

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;
    logic [15:0] perf_squashed_q;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q  <= '0;
            perf_stall_q    <= '0;
            perf_squashed_q <= '0;
        end else begin
            if (pop)                       perf_fetched_q  <= perf_fetched_q + 32'd1;
            if (inst_valid && !inst_ready) perf_stall_q    <= perf_stall_q + 32'd1;
            if (redirect_valid)            perf_squashed_q <= perf_squashed_q + 16'(occupancy);
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_stall    = perf_stall_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a 2-cycle (address reg + data reg) memory model.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic [14:0] imem_raddr;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [15:0] perf_squashed;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ifetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_raddr    (imem_raddr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall),
        .perf_squashed (perf_squashed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(logic [14:0] a);
        return 16'h1000 + {1'b0, a};
    endfunction

    logic [14:0] mem_addr_q;
    logic [15:0] mem_data_q;
    always_ff @(posedge clk) begin
        mem_addr_q <= imem_raddr;
        mem_data_q <= mem_word(mem_addr_q);
    end
    assign imem_rdata = mem_data_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample point: 2 time units after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for the next handshake, returning its pc/data; ends on the next sample point.
    task automatic get_xfer(output logic got, output logic [15:0] pc, output logic [15:0] data);
        got  = 1'b0;
        pc   = '0;
        data = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (inst_valid && inst_ready) begin
                got  = 1'b1;
                pc   = inst_pc;
                data = inst_data;
            end
            next_cycle();
        end
    endtask

    task automatic expect_xfer(input string name, input logic [15:0] pc, input logic [15:0] data);
        logic        got;
        logic [15:0] apc, adata;
        get_xfer(got, apc, adata);
        if (!got) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_pc"}, 32'(apc), 32'(pc));
            chk({name, "_data"}, 32'(adata), 32'(data));
        end
    endtask

    typedef struct {
        logic        ready;
        logic        redir;
        logic [15:0] rpc;
        logic        exp_v;
        logic [15:0] exp_pc;
        logic [15:0] exp_data;
        logic [14:0] exp_raddr;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Per-cycle vectors from reset release: streaming, then back-to-back redirects.
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 15'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 15'h0001};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 15'h0002};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1000, 15'h0003};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1001, 15'h0004};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h1002, 15'h0005};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h1003, 15'h0006};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'h1004, 15'h0007};
        vecs[8]  = '{1'b1, 1'b1, 16'h0200, 1'b0, 16'h0000, 16'h0000, 15'h0008};
        vecs[9]  = '{1'b1, 1'b1, 16'h0101, 1'b0, 16'h0000, 16'h0000, 15'h0100};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 15'h0080};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 15'h0081};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 15'h0082};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100, 16'h1080, 15'h0083};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0102, 16'h1081, 15'h0084};

        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        #3;
        chk("reset_valid", 32'(inst_valid), 32'd0);
        chk("reset_raddr", 32'(imem_raddr), 32'd0);
        chk("reset_data", 32'(inst_data), 32'd0);
        chk("reset_pc", 32'(inst_pc), 32'd0);

        // Table: streaming and redirects.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            inst_ready     = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_v));
            chk($sformatf("vec%0d_raddr", i), 32'(imem_raddr), 32'(vecs[i].exp_raddr));
            if (vecs[i].exp_v) begin
                chk($sformatf("vec%0d_pc", i), 32'(inst_pc), 32'(vecs[i].exp_pc));
                chk($sformatf("vec%0d_data", i), 32'(inst_data), 32'(vecs[i].exp_data));
            end
        end
        redirect_valid = 1'b0;

        // Stall from reset: buffer fills to 4, issue stops, then drains in order.
        do_reset();
        repeat (10) next_cycle();
        chk("stall_raddr", 32'(imem_raddr), 32'h4);
        chk("stall_valid", 32'(inst_valid), 32'd1);
        chk("stall_pc", 32'(inst_pc), 32'h0);
        chk("stall_data", 32'(inst_data), 32'h1000);
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            expect_xfer($sformatf("drain%0d", i), 16'(2 * i), 16'(16'h1000 + i));

        // Redirect from a full buffer.
        do_reset();
        repeat (10) next_cycle();
`ifdef IFETCH_PERF_EN
        chk("perf_stall", perf_stall, 32'd7);
`endif
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        #1;
        chk("redir_valid_c0", 32'(inst_valid), 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        chk("redir_raddr", 32'(imem_raddr), 32'h80);
        chk("redir_valid_c1", 32'(inst_valid), 32'd0);
`ifdef IFETCH_PERF_EN
        chk("perf_squashed", 32'(perf_squashed), 32'd4);
        chk("perf_fetched0", perf_fetched, 32'd0);
`endif
        next_cycle();
        chk("redir_valid_c2", 32'(inst_valid), 32'd0);
        next_cycle();
        chk("redir_valid_c3", 32'(inst_valid), 32'd0);
        next_cycle();
        chk("redir_valid_c4", 32'(inst_valid), 32'd1);
        expect_xfer("redir_t0", 16'h0100, 16'h1080);
        expect_xfer("redir_t1", 16'h0102, 16'h1081);

        // Redirect near the top of the address space: wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFC;
        next_cycle();
        redirect_valid = 1'b0;
        chk("wrap_raddr0", 32'(imem_raddr), 32'h7FFE);
        next_cycle();
        chk("wrap_raddr1", 32'(imem_raddr), 32'h7FFF);
        next_cycle();
        chk("wrap_raddr2", 32'(imem_raddr), 32'h0000);
        expect_xfer("wrap0", 16'hFFFC, 16'h8FFE);
        expect_xfer("wrap1", 16'hFFFE, 16'h8FFF);
        expect_xfer("wrap2", 16'h0000, 16'h1000);
        expect_xfer("wrap3", 16'h0002, 16'h1001);

        // Asynchronous reset mid-stream, then the same first-fetch latency.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_raddr", 32'(imem_raddr), 32'd0);
`ifdef IFETCH_PERF_EN
        chk("mid_rst_perf_f", perf_fetched, 32'd0);
        chk("mid_rst_perf_s", perf_stall, 32'd0);
        chk("mid_rst_perf_q", 32'(perf_squashed), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            next_cycle();
            chk($sformatf("restart_valid_e%0d", e), 32'(inst_valid), (e == 3) ? 32'd1 : 32'd0);
        end
        chk("restart_pc", 32'(inst_pc), 32'h0);
        chk("restart_data", 32'(inst_data), 32'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
